// File: rtl/sb_config_ctrl.sv
// rtl/sb_config_ctrl.sv - shadow/active switch config register block with commit control
module sb_config_ctrl #(
   parameter logic [7:0]  CFG_ADDR  = 8'h00,
   parameter logic [31:0] CFG_RESET = 32'h00000C00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        cfg_write,
   input  logic [7:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic [31:0] cfg_rdata,
   output logic        cfg_rvalid,
   output logic        cfg_err,
   input  logic        commit,
   input  logic [1:0]  in_0_0,
   input  logic [1:0]  in_2_0,
   input  logic [1:0]  in_3_0,
   input  logic [1:0]  pe_output_0,
   output logic [1:0]  out_1_0
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WDONE  = 2'd1,
      RDONE  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] active_q, active_d;
   logic [7:0]  count_q, count_d;
   logic        pending_q, pending_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic        err_q, err_d;

   logic        hit_shadow, hit_active, hit_count, unmapped;
   logic        accept;
   logic [31:0] rd_sel;

   // Address decode; offsets wrap within the 8-bit address space
   assign hit_shadow = (cfg_addr == CFG_ADDR);
   assign hit_active = (cfg_addr == CFG_ADDR + 8'd1);
   assign hit_count  = (cfg_addr == CFG_ADDR + 8'd2);
   assign unmapped   = !(hit_shadow || hit_active || hit_count);

   // A pending commit takes priority over new requests, so ready drops for it
   assign cfg_ready  = rst_n && (state_q == IDLE) && !pending_q;
   assign accept     = cfg_valid && cfg_ready;

   assign cfg_rdata  = rdata_q;
   assign cfg_rvalid = rvalid_q;
   assign cfg_err    = err_q;

   // Read-data selection; unmapped reads return zero
   always_comb begin
      rd_sel = 32'h0;
      if (hit_shadow)      rd_sel = shadow_q;
      else if (hit_active) rd_sel = active_q;
      else if (hit_count)  rd_sel = {24'h0, count_q};
   end

   // Next-state logic: every non-IDLE state lasts exactly one cycle
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            if (pending_q)                                  state_d = COMMIT;
            else if (accept && cfg_write && hit_active)     state_d = COMMIT;
            else if (accept && cfg_write)                   state_d = WDONE;
            else if (accept)                                state_d = RDONE;
            else if (commit)                                state_d = COMMIT;
            else                                            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Commit bookkeeping: an external commit that cannot start right away is
   // remembered; repeated pulses collapse into the single pending flag
   always_comb begin
      pending_d = pending_q;
      if ((state_q == IDLE) && !accept && (pending_q || commit)) pending_d = 1'b0;
      else if (commit)                                             pending_d = 1'b1;
   end

   // Datapath next values: shadow on write, active/count on the COMMIT cycle,
   // read response and error pulses on the accept edge
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      if (accept && cfg_write && hit_shadow) shadow_d = cfg_wdata;
      if (state_q == COMMIT) begin
         active_d = shadow_q;
         count_d  = count_q + 8'd1;
      end
      if (accept && !cfg_write) begin
         rdata_d  = rd_sel;
         rvalid_d = 1'b1;
      end
      if (accept && unmapped) err_d = 1'b1;
   end

   // State and register update with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shadow_q  <= CFG_RESET;
         active_q  <= CFG_RESET;
         count_q   <= 8'h00;
         pending_q <= 1'b0;
         rdata_q   <= 32'h0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
      end
   end

   // Output switch driven only by the committed configuration
   always_comb begin
      out_1_0 = pe_output_0;
      case (active_q[11:10])
         2'd0:    out_1_0 = in_0_0;
         2'd1:    out_1_0 = in_2_0;
         2'd2:    out_1_0 = in_3_0;
         default: out_1_0 = pe_output_0;
      endcase
   end

endmodule

// File: tb/tb_sb_config_ctrl.sv
// tb/tb_sb_config_ctrl.sv - self-checking bench for sb_config_ctrl
module tb_sb_config_ctrl;

   localparam logic [7:0]  BASE = 8'h00;
   localparam logic [31:0] RST  = 32'h00000C00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid, cfg_ready, cfg_write;
   logic [7:0]  cfg_addr;
   logic [31:0] cfg_wdata, cfg_rdata;
   logic        cfg_rvalid, cfg_err, commit;
   logic [1:0]  in_0_0, in_2_0, in_3_0, pe_output_0, out_1_0;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] m_shadow, m_active;
   logic [7:0]  m_count;

   logic [31:0] r_rdata;
   logic        r_rvalid, r_err;

   sb_config_ctrl #(.CFG_ADDR(BASE), .CFG_RESET(RST)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .cfg_rvalid(cfg_rvalid), .cfg_err(cfg_err), .commit(commit),
      .in_0_0(in_0_0), .in_2_0(in_2_0), .in_3_0(in_3_0),
      .pe_output_0(pe_output_0), .out_1_0(out_1_0)
   );

   always #5 clk = ~clk;

   initial begin
      #500us;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_out(input logic [31:0] act);
      logic [1:0] src [4];
      src[0] = in_0_0;
      src[1] = in_2_0;
      src[2] = in_3_0;
      src[3] = pe_output_0;
      return src[act[11:10]];
   endfunction

   // Drives one request, waits (bounded) for acceptance; returns at the
   // negedge of the cycle after the accept edge with response sampled.
   task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_write = w; cfg_addr = a; cfg_wdata = d;
      while (!cfg_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) check("ready_timeout", {31'h0, cfg_ready}, 32'h1);
      @(negedge clk);
      cfg_valid = 1'b0;
      r_rdata = cfg_rdata; r_rvalid = cfg_rvalid; r_err = cfg_err;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
      do_req(1'b0, a, 32'h0);
      check({tag, "_rvalid"}, {31'h0, r_rvalid}, 32'h1);
      check({tag, "_rdata"}, r_rdata, exp);
      check({tag, "_err"}, {31'h0, r_err}, 32'h0);
   endtask

   task automatic commit_write();
      do_req(1'b1, BASE + 8'd1, $urandom);
      m_active = m_shadow;
      m_count  = m_count + 8'd1;
      @(negedge clk);
   endtask

   initial begin
      logic prev_acc, rdy;
      logic [31:0] d;
      int op, k;

      rst_n = 1'b0; cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = 8'h0;
      cfg_wdata = 32'h0; commit = 1'b0;
      in_0_0 = 2'b01; in_2_0 = 2'b00; in_3_0 = 2'b11; pe_output_0 = 2'b10;
      m_shadow = RST; m_active = RST; m_count = 8'h0;

      // Reset state
      idle(3);
      check("rst_ready", {31'h0, cfg_ready}, 32'h0);
      check("rst_rvalid", {31'h0, cfg_rvalid}, 32'h0);
      check("rst_err", {31'h0, cfg_err}, 32'h0);
      check("rst_rdata", cfg_rdata, 32'h0);
      check("rst_out", {30'h0, out_1_0}, 32'h2);
      rst_n = 1'b1;
      #1 check("first_ready", {31'h0, cfg_ready}, 32'h1);

      // Basic readback of active after reset
      read_chk("r038_active", BASE + 8'd1, 32'h00000C00);
      check("r038_out", {30'h0, out_1_0}, 32'h2);

      // Shadow write, readback, commit latency
      in_0_0 = 2'b00; in_2_0 = 2'b01; in_3_0 = 2'b10; pe_output_0 = 2'b11;
      do_req(1'b1, BASE, 32'h00000400);
      m_shadow = 32'h00000400;
      read_chk("r039_shadow", BASE, 32'h00000400);
      check("r039_out_unch", {30'h0, out_1_0}, 32'h3);
      do_req(1'b1, BASE + 8'd1, 32'hDEADBEEF);
      check("r039_out_pre", {30'h0, out_1_0}, 32'h3);
      @(negedge clk);
      m_active = m_shadow; m_count = m_count + 8'd1;
      check("r039_out_post", {30'h0, out_1_0}, 32'h1);
      read_chk("r039_count", BASE + 8'd2, 32'h1);

      // Back-to-back reads with valid held high
      @(negedge clk);
      cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = BASE + 8'd2;
      prev_acc = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rdy = cfg_ready;
         check("b2b_ready", {31'h0, rdy}, {31'h0, ~prev_acc});
         check("b2b_rvalid", {31'h0, cfg_rvalid}, {31'h0, prev_acc});
         if (prev_acc) check("b2b_rdata", cfg_rdata, {24'h0, m_count});
         prev_acc = rdy;
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      idle(2);

      // Shadow write and external commit on the same edge
      @(negedge clk);
      cfg_valid = 1'b1; cfg_write = 1'b1; cfg_addr = BASE; cfg_wdata = 32'h00000800;
      commit = 1'b1;
      check("r041_ready", {31'h0, cfg_ready}, 32'h1);
      @(negedge clk);
      cfg_valid = 1'b0; commit = 1'b0;
      m_shadow = 32'h00000800;
      for (int i = 0; i < 3; i++) begin
         check("r041_busy", {31'h0, cfg_ready}, 32'h0);
         @(negedge clk);
      end
      check("r041_ready_back", {31'h0, cfg_ready}, 32'h1);
      m_active = m_shadow; m_count = m_count + 8'd1;
      check("r041_out", {30'h0, out_1_0}, {30'h0, in_3_0});
      read_chk("r041_active", BASE + 8'd1, 32'h00000800);
      read_chk("r041_count", BASE + 8'd2, {24'h0, m_count});

      // Unmapped read
      do_req(1'b0, 8'h07, 32'h0);
      check("r042_rdata", r_rdata, 32'h0);
      check("r042_rvalid", {31'h0, r_rvalid}, 32'h1);
      check("r042_err", {31'h0, r_err}, 32'h1);
      read_chk("r042_shadow", BASE, m_shadow);
      read_chk("r042_active", BASE + 8'd1, m_active);
      read_chk("r042_count", BASE + 8'd2, {24'h0, m_count});

      // Randomized operation mix against the reference model
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 5);
         d  = $urandom;
         case (op)
            0: begin
               do_req(1'b1, BASE, d);
               m_shadow = d;
               check("rnd_w_err", {31'h0, r_err}, 32'h0);
            end
            1: commit_write();
            2: begin
               k = $urandom_range(0, 2);
               if (k == 0)      read_chk("rnd_rd_sh", BASE, m_shadow);
               else if (k == 1) read_chk("rnd_rd_ac", BASE + 8'd1, m_active);
               else             read_chk("rnd_rd_ct", BASE + 8'd2, {24'h0, m_count});
            end
            3: begin
               do_req(1'b0, 8'($urandom_range(3, 255)), 32'h0);
               check("rnd_ur_rdata", r_rdata, 32'h0);
               check("rnd_ur_err", {31'h0, r_err}, 32'h1);
            end
            4: begin
               do_req(1'b1, 8'($urandom_range(3, 255)), d);
               check("rnd_uw_err", {31'h0, r_err}, 32'h1);
               check("rnd_uw_rvalid", {31'h0, r_rvalid}, 32'h0);
            end
            default: begin
               @(negedge clk);
               commit = 1'b1;
               @(negedge clk);
               commit = 1'b0;
               m_active = m_shadow; m_count = m_count + 8'd1;
            end
         endcase
         idle(3);
         in_0_0 = 2'($urandom); in_2_0 = 2'($urandom);
         in_3_0 = 2'($urandom); pe_output_0 = 2'($urandom);
         #1 check("rnd_out", {30'h0, out_1_0}, {30'h0, exp_out(m_active)});
      end
      read_chk("rnd_final_ac", BASE + 8'd1, m_active);

      // Reset asserted during COMMIT aborts the commit
      do_req(1'b1, BASE, 32'h00000000);
      m_shadow = 32'h0;
      do_req(1'b1, BASE + 8'd1, 32'h0);
      rst_n = 1'b0;
      #1;
      check("r043_rst_ready", {31'h0, cfg_ready}, 32'h0);
      check("r043_rst_out", {30'h0, out_1_0}, {30'h0, pe_output_0});
      idle(2);
      rst_n = 1'b1;
      m_shadow = RST; m_active = RST; m_count = 8'h0;
      read_chk("r043_active", BASE + 8'd1, RST);
      read_chk("r043_shadow", BASE, RST);
      read_chk("r043_count0", BASE + 8'd2, 32'h0);

      // Commit counter wrap after 256 commits
      for (int i = 0; i < 256; i++) commit_write();
      read_chk("r043_wrap", BASE + 8'd2, {24'h0, m_count});
      check("r043_wrap_model", {24'h0, m_count}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/sb_config_ctrl.md
SB_CONFIG_CTRL -- requirements
Module: sb_config_ctrl

Interface
REQ-001 Parameter CFG_ADDR, default 8'h00, is the base address of the register window.
REQ-002 Parameter CFG_RESET, default 32'h00000C00, is the reset value of the shadow and active config registers.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port cfg_valid, input, 1 bit: config request valid.
REQ-006 Port cfg_ready, output, 1 bit: controller can accept a request.
REQ-007 Port cfg_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port cfg_addr, input, 8 bits: register address.
REQ-009 Port cfg_wdata, input, 32 bits: write data.
REQ-010 Port cfg_rdata, output, 32 bits: read data.
REQ-011 Port cfg_rvalid, output, 1 bit: read data valid, one-cycle pulse.
REQ-012 Port cfg_err, output, 1 bit: unmapped-address pulse.
REQ-013 Port commit, input, 1 bit: external commit request pulse.
REQ-014 Port in_0_0, in_2_0, in_3_0, pe_output_0, input, 2 bits each: switch data sources.
REQ-015 Port out_1_0, output, 2 bits: switched output.

Function
REQ-016 Request accepted at a rising edge where cfg_valid && cfg_ready; cfg_ready = (state == IDLE); requester holds signals stable until accepted.
REQ-017 FSM states IDLE, WDONE, RDONE, COMMIT; all non-IDLE states last exactly one cycle and return to IDLE.
REQ-018 Address map: CFG_ADDR = shadow (R/W); CFG_ADDR+1 = active (read) / commit trigger (write, data ignored); CFG_ADDR+2 = commit_count (read-only, zero-extended, writes ignored).
REQ-019 Write to CFG_ADDR: shadow <= cfg_wdata at the accept edge; next state WDONE.
REQ-020 Write to CFG_ADDR+1: next state COMMIT; at the following edge active <= shadow, commit_count <= commit_count+1.
REQ-021 commit_count is 8 bits and wraps 255 -> 0.
REQ-022 Read: at the accept edge cfg_rdata <= selected register and cfg_rvalid <= 1; next state RDONE; cfg_rvalid = 1 for exactly that one cycle.
REQ-023 cfg_rdata holds its last value while cfg_rvalid = 0.
REQ-024 Unmapped address (read or write): no register change; cfg_err = 1 for one cycle after the accept edge.
REQ-025 Unmapped read additionally returns cfg_rdata = 0 with cfg_rvalid = 1.
REQ-026 External commit in IDLE with no accept on the same edge: next state COMMIT.
REQ-027 External commit in any other case: set commit_pending.
REQ-028 In IDLE with commit_pending = 1: next state COMMIT (clearing pending) before any new request; cfg_ready = 0 for that cycle.
REQ-029 Multiple commit pulses while pending collapse into one commit.
REQ-030 A write to the shadow in the same cycle as an external commit: the commit copies the new shadow value.
REQ-031 out_1_0 is combinational from active[11:10]: 0 -> in_0_0, 1 -> in_2_0, 2 -> in_3_0, 3 -> pe_output_0.
REQ-032 Shadow writes never affect out_1_0 until committed.
REQ-033 Latency: out_1_0 reflects new active config starting the cycle after the COMMIT state's edge (two edges after the commit-write accept).

Reset
REQ-034 rst_n = 0 asynchronously forces state = IDLE, shadow = active = CFG_RESET, commit_count = 0, commit_pending = 0, cfg_rdata = 0, cfg_rvalid = 0, cfg_err = 0.
REQ-035 During reset cfg_ready = 0; with default CFG_RESET, out_1_0 = pe_output_0.
REQ-036 Reset asserted mid-operation (any state) aborts it; no partial commit survives.
REQ-037 First request can be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-038 Reset release, pe_output_0=2'b10, in_0_0=2'b01 -> out_1_0=2'b10; read CFG_ADDR+1 -> 32'h00000C00.
REQ-039 Write shadow 32'h00000400, read CFG_ADDR -> 32'h00000400; out_1_0 unchanged; write CFG_ADDR+1 -> 2 edges later out_1_0 = in_2_0; commit_count = 1.
REQ-040 Back-to-back requests with cfg_valid held high -> cfg_ready low every second cycle; each read gives exactly one cfg_rvalid pulse.
REQ-041 commit pulse on the same edge a shadow write of 32'h00000800 is accepted -> WDONE, then COMMIT; active = 32'h00000800; out_1_0 = in_3_0; commit_count +1 only.
REQ-042 Read address 8'h07 (CFG_ADDR=0) -> cfg_rdata=0, cfg_rvalid=1, cfg_err=1, all registers unchanged.
REQ-043 256 commits -> commit_count reads 0; rst_n pulsed low during COMMIT -> active = CFG_RESET, count = 0.
